// File: rtl/weakgpio_pkg.sv
// Shared constants for the weakgpio peripheral: register offsets, handshake
// state encoding and the byte-lane mask helper.
package weakgpio_pkg;

    localparam logic [2:0] REG_DATA_OUT   = 3'd0;
    localparam logic [2:0] REG_DIR        = 3'd1;
    localparam logic [2:0] REG_DATA_IN    = 3'd2;
    localparam logic [2:0] REG_SET        = 3'd3;
    localparam logic [2:0] REG_CLR        = 3'd4;
    localparam logic [2:0] REG_IRQ_EN     = 3'd5;
    localparam logic [2:0] REG_IRQ_EDGE   = 3'd6;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    function automatic logic [31:0] lane_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/weakgpio_sync.sv
// Pad input synchroniser with a previous-value flop; exposes the synchronised
// value and per-bit rising/falling edge strobes.
module weakgpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_pad,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_data = r_sync[SYNC_STAGES-1];
    assign o_rise = o_data & ~r_prev;
    assign o_fall = ~o_data & r_prev;

endmodule

// File: rtl/weakgpio.sv
// GPIO peripheral on the weakcore bus: direction, set/clear outputs, synchronised
// input readback and per-pin edge interrupts behind a one-cycle ack handshake.
module weakgpio
    import weakgpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             wr,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    output logic [31:0]      rdata,
    output logic             ack,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_out, r_dir, r_en, r_edge, r_stat;
    logic [0:0]       r_state;
    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [2:0]       r_arm;

    logic [WIDTH-1:0] w_din, w_rise, w_fall, w_hit, w_bm, w_wd, w_w1c;
    logic [31:0]      w_lane, w_rd;
    logic             w_accept, w_we, w_armed;
    logic             w_unused;

    weakgpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pad  (gpio_in),
        .o_data (w_din),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_lane   = lane_mask(wmask);
    assign w_bm     = w_lane[WIDTH-1:0];
    assign w_wd     = wdata[WIDTH-1:0] & w_bm;
    assign w_accept = (r_state == ST_IDLE) && sel;
    assign w_we     = w_accept && wr;
    assign w_armed  = (r_arm == ARM_MAX);
    // Edges are ignored until the synchroniser has flushed its reset zeros.
    assign w_hit    = w_armed ? ((r_edge & w_rise) | (~r_edge & w_fall)) : '0;
    assign w_w1c    = (w_we && addr == REG_IRQ_STATUS) ? w_wd : '0;
    assign w_unused = &{1'b0, wdata, w_lane};

    always_comb begin
        w_rd = '0;
        case (addr)
            REG_DATA_OUT:   w_rd[WIDTH-1:0] = r_out;
            REG_DIR:        w_rd[WIDTH-1:0] = r_dir;
            REG_DATA_IN:    w_rd[WIDTH-1:0] = w_din;
            REG_IRQ_EN:     w_rd[WIDTH-1:0] = r_en;
            REG_IRQ_EDGE:   w_rd[WIDTH-1:0] = r_edge;
            REG_IRQ_STATUS: w_rd[WIDTH-1:0] = r_stat;
            default:        w_rd = '0;
        endcase
    end

    // sel is not sampled in ACK, so a held request completes every other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_accept ? ST_ACK : ST_IDLE;
            r_ack   <= w_accept;
            r_rdata <= (w_accept && !wr) ? w_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_en   <= '0;
            r_edge <= '0;
        end else if (w_we) begin
            case (addr)
                REG_DATA_OUT: r_out  <= (r_out & ~w_bm) | w_wd;
                REG_DIR:      r_dir  <= (r_dir & ~w_bm) | w_wd;
                REG_SET:      r_out  <= r_out | w_wd;
                REG_CLR:      r_out  <= r_out & ~w_wd;
                REG_IRQ_EN:   r_en   <= (r_en & ~w_bm) | w_wd;
                REG_IRQ_EDGE: r_edge <= (r_edge & ~w_bm) | w_wd;
                default:      ;
            endcase
        end
    end

    // A new edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat <= '0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | w_hit;
        end
    end

    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_stat & r_en);

endmodule

// File: doc/weakgpio.md
Name: weakgpio

Overview:
- Parametrised GPIO peripheral on the weakcore bus; successor to the single write-only LED bit in the SoC top.
- Provides WIDTH pins with per-pin direction, set/clear output access, synchronised input readback, and per-pin edge interrupts behind a registered one-cycle bus handshake.
- Sits behind the SoC address decoder, which drives sel; irq feeds a future interrupt input.

Parameters:
- WIDTH, 8, number of GPIO pins, 1..32; register bits at and above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser, 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- sel  input  1  decoded bus request for this block (bus_req & address match).
- wr  input  1  1 = write, 0 = read.
- addr  input  3  word offset, bus_addr[4:2].
- wdata  input  32  write data from the core.
- wmask  input  4  byte-lane write enables.
- rdata  output  32  read data; valid only while ack=1, otherwise 0.
- ack  output  1  one-cycle completion pulse.
- gpio_in  input  WIDTH  asynchronous pad inputs.
- gpio_out  output  WIDTH  output data register.
- gpio_oe  output  WIDTH  output enables (DIR register).
- irq  output  1  level interrupt = |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Register map (addr value):
  - 0 DATA_OUT, RW.
  - 1 DIR, RW; 1 = output.
  - 2 DATA_IN, RO; synchronised pins.
  - 3 SET, WO; writing 1 sets the matching DATA_OUT bit.
  - 4 CLR, WO; writing 1 clears the matching DATA_OUT bit.
  - 5 IRQ_EN, RW.
  - 6 IRQ_EDGE, RW; 1 = rising, 0 = falling.
  - 7 IRQ_STATUS, RW1C.
  - SET and CLR read as 0.
- Reset: all registers 0, synchroniser and previous-value flops 0, ack=0, rdata=0, gpio_out=0, gpio_oe=0, irq=0, arm counter 0.
- Handshake uses a two-state FSM:
  - IDLE: sel=1 accepts the request; goes to ACK.
  - ACK: ack=1 for exactly one cycle; returns to IDLE unconditionally.
  - sel is ignored while in ACK, so sel held continuously yields one access per two cycles.
- Write commits on the accepting edge. Byte lane n updates bits [8n+7:8n] only when wmask[n]=1. wr=1 on a RO register is accepted and acked, with no effect.
- Read data is captured on the accepting edge and presented on rdata during the ACK cycle. Latency: request-to-ack = 1 cycle.
- Input path: gpio_in passes through SYNC_STAGES flops to DATA_IN. A prev flop holds the prior DATA_IN value.
  - Rising edge = DATA_IN & ~prev; falling edge = ~DATA_IN & prev; IRQ_EDGE selects per bit.
  - A detected edge sets the IRQ_STATUS bit independently of DIR and IRQ_EN.
- Arming: a saturating counter gates edge detection until SYNC_STAGES+1 cycles after reset release. This prevents spurious edges from reset-zeroed flops.
- Timing: a pad change appears in DATA_IN after SYNC_STAGES edges; the status bit sets on the next edge; irq rises the same cycle (combinational from registers).
- A simultaneous W1C and new edge on the same status bit leaves the bit set (set wins).
- Asserting rst mid-transaction aborts it: the FSM returns to IDLE and no ack is issued.

Decomposition:
- Package weakgpio_pkg holds the register offset constants (REG_DATA_OUT..REG_IRQ_STATUS) and the FSM state encoding.
- One sub-module, weakgpio_sync (parameter SYNC_STAGES, width WIDTH), holds the synchroniser, prev flop and rising/falling edge outputs.
- Register file, arming counter and handshake FSM stay in weakgpio.

Test Plan:
- Reset state: after reset release all outputs are 0. Read each address → rdata=0, ack exactly one cycle after sel.
- Write DIR=0xFF and DATA_OUT=0xA5 with wmask=4'b0001, then SET 0x02, then CLR 0x80 → gpio_oe=0xFF; gpio_out=0xA5, 0xA7, 0x27 in turn. Writing 0xFFFF_FF00 with wmask=4'b0010 at WIDTH=8 leaves DATA_OUT unchanged.
- Input latency: gpio_in 0x00→0x01 → DATA_IN reads 0x01 from SYNC_STAGES edges later. With IRQ_EDGE[0]=1 and IRQ_EN[0]=1, IRQ_STATUS=0x01 and irq=1 one edge after that. Write 0x01 to IRQ_STATUS → irq=0 next cycle.
- Falling edge and set-wins: IRQ_EDGE[3]=0, pin 3 falls on the same edge as a W1C of bit 3 → IRQ_STATUS[3] stays 1.
- Arming: hold gpio_in=0xFF through reset release → IRQ_STATUS remains 0x00.
- Handshake stress: sel held high for 6 cycles → exactly 3 ack pulses. rst pulled low in the ACK cycle → ack=0 immediately and no register changes.
